// File: rtl/ctrl_encode_def.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_encode_def (package)
// Purpose  : Shared encodings for the multiply/divide unit. This file holds
//            the MULT/MULTU/DIV/DIVU op codes that the execute stage drives.
//            It also holds the state encoding of the iterative sequencer.
// Contents : MD_MULT, MD_MULTU, MD_DIV, MD_DIVU  - 2-bit op codes
//            md_state_t {MD_IDLE, MD_RUN, MD_FIX} - sequencer states
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_encode_def;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/md_signfix.sv
`default_nettype none
// ============================================================================
// Module   : md_signfix
// Purpose  : Conditional two's-complement negate of a W-bit value. This block
//            is purely combinational. It is used both to take operand
//            magnitudes and to restore the sign of results.
// Ports    : neg  in  1  negate when high
//            din  in  W  value
//            dout out W  din or -din
// Revision : 1.0 - initial release
// ============================================================================
module md_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit with architectural HI/LO.
//            It performs shift-add multiplication and restoring division on
//            operand magnitudes, taking one bit per cycle. A final FIX cycle
//            restores the signs of the results and writes HI/LO.
// Ports    : clk    in  1      system clock, rising edge
//            rst    in  1      asynchronous active-high reset
//            start  in  1      launch operation (sampled only when idle)
//            op     in  2      MULT / MULTU / DIV / DIVU
//            a, b   in  WIDTH  rs / rt operands
//            hi_wr  in  1      MTHI strobe (idle only)
//            lo_wr  in  1      MTLO strobe (idle only)
//            wdata  in  WIDTH  MTHI/MTLO data
//            busy   out 1      operation in flight
//            done   out 1      one-cycle pulse with the HI/LO update
//            hi, lo out WIDTH  HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  md_state_t            r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide  : {remainder, quotient / unconsumed dividend bits}.
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;     // multiplicand or divisor magnitude
  logic                 r_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_dz;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // MULT and DIV (op[0] == 0) are the signed flavours.
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];

  md_signfix #(.W(WIDTH)) u_abs_a (.neg(w_a_neg), .din(a), .dout(w_a_mag));
  md_signfix #(.W(WIDTH)) u_abs_b (.neg(w_b_neg), .din(b), .dout(w_b_mag));

  // Shift-add step: add the multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right. The carry moves into the top bit.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, r_opnd & {WIDTH{r_acc[0]}}};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: {rem, quot} << 1 is taken as a (WIDTH+1)-bit window, so the
  // compare sees the bit shifted out of rem. The difference fits in WIDTH bits
  // whenever it is kept.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};

  md_signfix #(.W(2*WIDTH)) u_fix_prod (
    .neg(r_neg_res), .din(r_acc), .dout(w_prod_fix)
  );
  md_signfix #(.W(WIDTH)) u_fix_quot (
    .neg(r_neg_res), .din(r_acc[WIDTH-1:0]), .dout(w_quot_fix)
  );
  md_signfix #(.W(WIDTH)) u_fix_rem (
    .neg(r_neg_rem), .din(r_acc[2*WIDTH-1:WIDTH]), .dout(w_rem_fix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          // MT writes land even alongside start; FIX overwrites them later.
          if (hi_wr) r_hi <= wdata;
          if (lo_wr) r_lo <= wdata;
          if (start) begin
            r_div     <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dz      <= (b == '0);
            r_opnd    <= op[1] ? w_b_mag : w_a_mag;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_cnt     <= c_cnt_init;
            r_busy    <= 1'b1;
            r_state   <= MD_RUN;
          end
        end
        MD_RUN: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - c_cnt_one;
          if (r_cnt == '0) r_state <= MD_FIX;
        end
        MD_FIX: begin
          if (r_div) begin
            // With a zero divisor every step subtracts nothing. The remainder
            // therefore ends as |a|, and its sign fix gives back the original a.
            // Only the quotient needs forcing.
            r_hi <= w_rem_fix;
            r_lo <= r_dz ? {WIDTH{1'b1}} : w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire
